prefetch_unit: RTL and testbench

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/prefetch_unit.sv | 85 ++++++++
 tb/tb_prefetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: fetches sequential words from memory into a small
// circular queue of {pc, instruction} entries, with redirect/flush and global freeze.
module prefetch_unit #(
  parameter int                XLEN     = 32,
  parameter int                DEPTH    = 4,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hlt,
  input  logic                        override,
  input  logic [XLEN-1:0]             newpc,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic [XLEN-1:0]             mem_addr,
  input  logic [XLEN-1:0]             mem_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN-1:0]             instruction,
  output logic [XLEN-1:0]             outpc,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   occ;
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] ins_mem [DEPTH];
  logic            push;
  logic            pop;

  // Both sides use valid/ready: a transfer happens in any cycle where valid and
  // ready are high together; valid never depends on ready.
  assign mem_valid   = !rst && !hlt && !override && (occ < FULL);
  assign out_valid   = !rst && !hlt && !override && (occ != '0);
  assign push        = mem_valid && mem_ready;
  assign pop         = out_valid && out_ready;
  assign mem_addr    = fetch_pc;
  assign instruction = ins_mem[rd_ptr];
  assign outpc       = pc_mem[rd_ptr];
  assign count       = occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
    end else if (!hlt) begin
      if (override) begin
        fetch_pc <= {newpc[XLEN-1:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        occ      <= '0;
      end else begin
        if (push) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          wr_ptr   <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push, pop})
          2'b10:   occ <= occ + CW'(1);
          2'b01:   occ <= occ - CW'(1);
          default: occ <= occ;
        endcase
      end
    end
  end

  // Queue storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= fetch_pc;
      ins_mem[wr_ptr] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: fill, drain, redirect, stream, freeze,
// address wrap and asynchronous reset, with hand-computed expectations.
module tb_prefetch_unit;

  localparam logic [31:0] TAG = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        hlt;
  logic        override;
  logic [31:0] newpc;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic [31:0] outpc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .hlt         (hlt),
    .override    (override),
    .newpc       (newpc),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instruction (instruction),
    .outpc       (outpc),
    .count       (count)
  );

  // Memory returns a word tagged with its own address.
  assign mem_rdata = mem_addr ^ TAG;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_outpc"}, outpc, pc);
    chk({tag, "_instr"}, instruction, pc ^ TAG);
  endtask

  initial begin
    rst = 1'b1; hlt = 1'b0; override = 1'b0; newpc = '0;
    mem_ready = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_mem_addr",  mem_addr,       32'h0);

    // Fill with no consumer.
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    chk("fill_first_valid", 32'(mem_valid), 32'd1);
    chk("fill_first_addr",  mem_addr,       32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("fill_count", 32'(count), 32'(k));
      chk("fill_addr",  mem_addr,   32'(4 * k));
    end
    chk("full_mem_valid", 32'(mem_valid), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk_head("full_head", 32'h0);
    tick();
    chk("full_hold_valid", 32'(mem_valid), 32'd0);
    chk("full_hold_count", 32'(count),     32'd4);

    // Single dequeue from full.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("deq_count",     32'(count),     32'd3);
    chk_head("deq_head", 32'h4);
    chk("deq_mem_valid", 32'(mem_valid), 32'd1);
    chk("deq_mem_addr",  mem_addr,       32'h10);

    // Redirect with count=3; unaligned target.
    mem_ready = 1'b0;
    override = 1'b1; newpc = 32'h103;
    #1;
    chk("ovr_mem_valid", 32'(mem_valid), 32'd0);
    chk("ovr_out_valid", 32'(out_valid), 32'd0);
    tick();
    override = 1'b0; mem_ready = 1'b1;
    #1;
    chk("ovr_count",     32'(count),     32'd0);
    chk("ovr_out_valid2", 32'(out_valid), 32'd0);
    chk("ovr_mem_addr",  mem_addr,       32'h100);
    tick();
    chk("ovr_fetch_count", 32'(count), 32'd1);
    chk_head("ovr_head", 32'h100);

    // Streaming: one word per cycle, occupancy held at 1.
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("stream_count", 32'(count), 32'd1);
      chk_head("stream_head", 32'h100 + 32'(4 * i));
    end
    chk("stream_addr", mem_addr, 32'h118);

    // Freeze overrides everything for three cycles.
    hlt = 1'b1; override = 1'b1; newpc = 32'h200;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("hlt_mem_valid", 32'(mem_valid), 32'd0);
      chk("hlt_out_valid", 32'(out_valid), 32'd0);
      chk("hlt_addr",      mem_addr,       32'h118);
      chk("hlt_count",     32'(count),     32'd1);
      chk_head("hlt_head", 32'h114);
      if (i < 3) tick();
    end
    hlt = 1'b0; override = 1'b0; out_ready = 1'b0;
    #1;
    chk("unhlt_out_valid", 32'(out_valid), 32'd1);
    chk_head("unhlt_head", 32'h114);

    // Address wrap at the top of the space.
    override = 1'b1; newpc = 32'hFFFF_FFFA;
    tick();
    override = 1'b0; out_ready = 1'b1;
    #1;
    chk("wrap_count0", 32'(count), 32'd0);
    chk("wrap_addr0",  mem_addr,   32'hFFFF_FFF8);
    tick();
    chk("wrap_addr1",   mem_addr, 32'hFFFF_FFFC);
    chk_head("wrap_h1", 32'hFFFF_FFF8);
    tick();
    chk("wrap_addr2",   mem_addr, 32'h0);
    chk_head("wrap_h2", 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr3",   mem_addr, 32'h4);
    chk_head("wrap_h3", 32'h0);

    // Asynchronous reset in the middle of a cycle.
    out_ready = 1'b0;
    tick();
    chk("pre_rst_count", 32'(count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count",     32'(count),     32'd0);
    chk("arst_mem_valid", 32'(mem_valid), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_addr",      mem_addr,       32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 32'(mem_valid), 32'd1);
    chk("post_rst_addr",  mem_addr,       32'h0);
    tick();
    chk("post_rst_count", 32'(count), 32'd1);
    chk_head("post_rst_head", 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
